// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer
// Owns the instruction fetch PC, drives the instruction memory address and
// buffers fetched words in a small prefetch queue that feeds decode over a
// valid/ready handshake. Redirects flush the queue and reload the PC; halt
// freezes fetching; an illegal fetch address parks the block in a sticky
// FAULT state until reset while already-queued words remain deliverable.
module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic                               Clk,
  input  logic                               Rst,
  output logic [31:0]                        ImemAddress,
  input  logic [31:0]                        ImemInstruction,
  input  logic                               RedirectValid,
  input  logic [31:0]                        RedirectTarget,
  input  logic                               Halt,
  output logic                               OutValid,
  input  logic                               OutReady,
  output logic [31:0]                        OutInstruction,
  output logic [31:0]                        OutPC,
  output logic [31:0]                        OutPCPlus4,
  output logic                               FetchFault,
  output logic [$clog2(BUF_DEPTH + 1)-1:0]   Occupancy
);

  // --------------------------------------------------------------------------
  // Local constants
  // --------------------------------------------------------------------------
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // First byte address past the end of instruction memory.
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Fetch control states.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // A fetch address is usable only if word aligned and inside the memory.
  function automatic logic addr_is_legal(input logic [31:0] addr);
    logic aligned;
    logic in_range;
    aligned  = (addr[1:0] == 2'b00);
    in_range = (addr < IMEM_BYTES);
    return aligned & in_range;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       state_r;
  logic [1:0]       state_n;
  logic [31:0]      fetch_pc_r;
  logic [31:0]      fetch_pc_n;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] wr_ptr_n;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_n;
  logic             fault_r;
  logic             fault_n;

  // Queue storage: each entry carries the word, its PC and PC+4 so the
  // head fields come straight out of registers.
  logic [31:0] q_instr_r [BUF_DEPTH];
  logic [31:0] q_pc_r    [BUF_DEPTH];
  logic [31:0] q_pc4_r   [BUF_DEPTH];

  // --------------------------------------------------------------------------
  // Per-cycle decisions
  // --------------------------------------------------------------------------
  logic head_valid_s;
  logic pop_s;
  logic push_s;
  logic redirect_s;
  logic room_s;
  logic fetch_en_s;
  logic pc_legal_s;
  logic target_legal_s;

  // Derive handshake, redirect and push qualifiers from registered state.
  always_comb begin
    head_valid_s   = (count_r != CNT_ZERO);
    pop_s          = head_valid_s & OutReady;
    pc_legal_s     = addr_is_legal(fetch_pc_r);
    target_legal_s = addr_is_legal(RedirectTarget);
    fetch_en_s     = (state_r == ST_RUN);
    // FAULT ignores redirects entirely; RUN and HALTED both accept them.
    redirect_s     = RedirectValid & (state_r != ST_FAULT);
    // A full queue still accepts a push when the head leaves this cycle.
    room_s         = (count_r < CNT_FULL) | pop_s;
    push_s         = fetch_en_s & ~RedirectValid & pc_legal_s & room_s;
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  // Choose the next fetch state and sticky fault flag.
  always_comb begin
    state_n = state_r;
    fault_n = fault_r;
    case (state_r)
      ST_RUN, ST_HALTED: begin
        if (redirect_s) begin
          if (target_legal_s) begin
            // Redirect itself never changes mode; Halt still decides it.
            state_n = Halt ? ST_HALTED : ST_RUN;
            fault_n = fault_r;
          end else begin
            state_n = ST_FAULT;
            fault_n = 1'b1;
          end
        end else if (!pc_legal_s) begin
          // Sequential fetch walked off the end of memory.
          state_n = ST_FAULT;
          fault_n = 1'b1;
        end else begin
          state_n = Halt ? ST_HALTED : ST_RUN;
          fault_n = fault_r;
        end
      end
      ST_FAULT: begin
        state_n = ST_FAULT;
        fault_n = 1'b1;
      end
      default: begin
        // Corrupted encoding: stop fetching and flag it.
        state_n = ST_FAULT;
        fault_n = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch PC
  // --------------------------------------------------------------------------
  // Redirect reloads the PC; a push advances it by one word.
  always_comb begin
    if (redirect_s) begin
      fetch_pc_n = RedirectTarget;
    end else if (push_s) begin
      fetch_pc_n = fetch_pc_r + WORD_BYTES;
    end else begin
      fetch_pc_n = fetch_pc_r;
    end
  end

  // --------------------------------------------------------------------------
  // Queue pointers and occupancy
  // --------------------------------------------------------------------------
  // Advance pointers on push/pop; a redirect empties the queue outright.
  always_comb begin
    rd_ptr_n = rd_ptr_r;
    wr_ptr_n = wr_ptr_r;
    count_n  = count_r;
    if (redirect_s) begin
      // Flush wins even over a simultaneous pop; the popped head is gone
      // with the rest of the queue, so it can never be re-presented.
      rd_ptr_n = PTR_ZERO;
      wr_ptr_n = PTR_ZERO;
      count_n  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_n = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_n = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_n = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_n = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_n = count_r + CNT_ONE;
        2'b01:   count_n = count_r - CNT_ONE;
        default: count_n = count_r;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Control and pointer registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r    <= ST_RUN;
      fetch_pc_r <= RESET_PC;
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      fetch_pc_r <= fetch_pc_n;
      rd_ptr_r   <= rd_ptr_n;
      wr_ptr_r   <= wr_ptr_n;
      count_r    <= count_n;
      fault_r    <= fault_n;
    end
  end

  // Queue storage: cleared on reset so the head fields read as zero.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        q_instr_r[i] <= 32'h0000_0000;
        q_pc_r[i]    <= 32'h0000_0000;
        q_pc4_r[i]   <= 32'h0000_0000;
      end
    end else if (push_s) begin
      q_instr_r[wr_ptr_r] <= ImemInstruction;
      q_pc_r[wr_ptr_r]    <= fetch_pc_r;
      q_pc4_r[wr_ptr_r]   <= fetch_pc_r + WORD_BYTES;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all driven from registered state only)
  // --------------------------------------------------------------------------
  assign ImemAddress    = fetch_pc_r;
  assign OutValid       = head_valid_s;
  assign OutInstruction = q_instr_r[rd_ptr_r];
  assign OutPC          = q_pc_r[rd_ptr_r];
  assign OutPCPlus4     = q_pc4_r[rd_ptr_r];
  assign FetchFault     = fault_r;
  assign Occupancy      = count_r;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed scenarios plus a randomized run
// compared against a queue-based reference model of the fetch rules.
module tb_imem_fetch_sequencer;

  logic        Clk;
  logic        Rst;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic        Halt;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstruction;
  logic [31:0] OutPC;
  logic [31:0] OutPCPlus4;
  logic        FetchFault;
  logic [1:0]  Occupancy;

  logic [31:0] mem [128];
  int total;
  int bad;

  // Reference model state
  localparam int M_RUN   = 0;
  localparam int M_HALT  = 1;
  localparam int M_FAULT = 2;
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  int          m_state;
  bit          m_fault;

  assign ImemInstruction = mem[ImemAddress[8:2]];

  imem_fetch_sequencer dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .ImemAddress    (ImemAddress),
    .ImemInstruction(ImemInstruction),
    .RedirectValid  (RedirectValid),
    .RedirectTarget (RedirectTarget),
    .Halt           (Halt),
    .OutValid       (OutValid),
    .OutReady       (OutReady),
    .OutInstruction (OutInstruction),
    .OutPC          (OutPC),
    .OutPCPlus4     (OutPCPlus4),
    .FetchFault     (FetchFault),
    .Occupancy      (Occupancy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic bit legal(input logic [31:0] a);
    return ((a % 32'd4) == 32'd0) && (a < 32'd512);
  endfunction

  // Apply one clock of the fetch rules to the model using current inputs.
  task automatic model_step();
    bit pop;
    logic [63:0] dropped;
    if (Rst) begin
      m_pc = 32'h0;
      m_q.delete();
      m_state = M_RUN;
      m_fault = 1'b0;
    end else begin
      pop = (m_q.size() > 0) && OutReady;
      if (m_state == M_FAULT) begin
        if (pop) dropped = m_q.pop_front();
      end else if (RedirectValid) begin
        m_q.delete();
        m_pc = RedirectTarget;
        if (!legal(RedirectTarget)) begin
          m_state = M_FAULT;
          m_fault = 1'b1;
        end else begin
          m_state = Halt ? M_HALT : M_RUN;
        end
      end else begin
        if (pop) dropped = m_q.pop_front();
        if (!legal(m_pc)) begin
          m_state = M_FAULT;
          m_fault = 1'b1;
        end else begin
          if (m_state == M_RUN && m_q.size() < 2) begin
            m_q.push_back({mem[m_pc[8:2]], m_pc});
            m_pc = m_pc + 32'd4;
          end
          m_state = Halt ? M_HALT : M_RUN;
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 128; i++) mem[i] = 32'(i * 4);
  endtask

  task automatic test_reset();
    logic [31:0] got [7];
    logic [31:0] want [7];
    string nm [7];
    fill_ramp();
    Rst = 1'b1; RedirectValid = 1'b1; RedirectTarget = 32'h40; Halt = 1'b0; OutReady = 1'b1;
    step();
    step();
    got[0] = ImemAddress;          want[0] = 32'h0; nm[0] = "reset_addr";
    got[1] = 32'(OutValid);        want[1] = 32'h0; nm[1] = "reset_valid";
    got[2] = 32'(Occupancy);       want[2] = 32'h0; nm[2] = "reset_occ";
    got[3] = OutInstruction;       want[3] = 32'h0; nm[3] = "reset_instr";
    got[4] = OutPC;                want[4] = 32'h0; nm[4] = "reset_pc";
    got[5] = OutPCPlus4;           want[5] = 32'h0; nm[5] = "reset_pc4";
    got[6] = 32'(FetchFault);      want[6] = 32'h0; nm[6] = "reset_fault";
    for (int i = 0; i < 7; i++) begin
      total++;
      if (got[i] !== want[i]) begin
        bad++;
        $display("FAIL %s: got %h want %h", nm[i], got[i], want[i]);
      end
    end
    Rst = 1'b0; RedirectValid = 1'b0;
  endtask

  task automatic test_stream();
    fill_ramp();
    OutReady = 1'b1; Halt = 1'b0; RedirectValid = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step();
      total++;
      if (OutValid !== 1'b1 || OutPC !== 32'(4 * c) || OutInstruction !== 32'(4 * c) ||
          OutPCPlus4 !== 32'(4 * c + 4) || Occupancy !== 2'd1) begin
        bad++;
        $display("FAIL stream c=%0d: got v=%b pc=%h ins=%h pc4=%h occ=%0d want v=1 pc=%h occ=1",
                 c, OutValid, OutPC, OutInstruction, OutPCPlus4, Occupancy, 32'(4 * c));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  exp_occ;
    logic [31:0] exp_addr;
    fill_ramp();
    OutReady = 1'b0; Halt = 1'b0; RedirectValid = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      exp_occ  = (c == 0) ? 2'd1 : 2'd2;
      exp_addr = (c == 0) ? 32'd4 : 32'd8;
      total++;
      if (Occupancy !== exp_occ || ImemAddress !== exp_addr || OutPC !== 32'd0 || OutValid !== 1'b1) begin
        bad++;
        $display("FAIL backpressure c=%0d: got occ=%0d addr=%h pc=%h want occ=%0d addr=%h pc=0",
                 c, Occupancy, ImemAddress, OutPC, exp_occ, exp_addr);
      end
    end
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    total++;
    if (Occupancy !== 2'd2 || ImemAddress !== 32'd12 || OutPC !== 32'd4) begin
      bad++;
      $display("FAIL pop_push_full: got occ=%0d addr=%h pc=%h want occ=2 addr=c pc=4",
               Occupancy, ImemAddress, OutPC);
    end
  endtask

  // Runs straight after test_backpressure: queue full, head PC 4.
  task automatic test_redirect();
    OutReady = 1'b1; RedirectValid = 1'b1; RedirectTarget = 32'h10;
    step();
    RedirectValid = 1'b0;
    total++;
    if (OutValid !== 1'b0 || Occupancy !== 2'd0 || ImemAddress !== 32'h10) begin
      bad++;
      $display("FAIL redirect_flush: got v=%b occ=%0d addr=%h want v=0 occ=0 addr=10",
               OutValid, Occupancy, ImemAddress);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (OutValid !== 1'b1 || OutPC !== 32'(16 + 4 * c) || OutInstruction !== 32'(16 + 4 * c)) begin
        bad++;
        $display("FAIL redirect_seq c=%0d: got v=%b pc=%h ins=%h want pc=%h",
                 c, OutValid, OutPC, OutInstruction, 32'(16 + 4 * c));
      end
    end
  endtask

  task automatic test_halt();
    bit seen;
    fill_ramp();
    OutReady = 1'b1; Halt = 1'b0; RedirectValid = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) step();
    Halt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (ImemAddress !== m_pc || Occupancy !== 2'(m_q.size())) begin
        bad++;
        $display("FAIL halt_model c=%0d: got addr=%h occ=%0d want addr=%h occ=%0d",
                 c, ImemAddress, Occupancy, m_pc, m_q.size());
      end
    end
    total++;
    if (Occupancy !== 2'd0 || ImemAddress !== 32'd24 || OutValid !== 1'b0) begin
      bad++;
      $display("FAIL halt_drain: got occ=%0d addr=%h v=%b want occ=0 addr=18 v=0",
               Occupancy, ImemAddress, OutValid);
    end
    Halt = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      step();
      if (OutValid) seen = 1'b1;
    end
    total++;
    if (!seen || OutPC !== 32'd24) begin
      bad++;
      $display("FAIL halt_resume: got seen=%b pc=%h want seen=1 pc=18", seen, OutPC);
    end
  endtask

  task automatic test_fault_target();
    logic [31:0] targets [2];
    targets[0] = 32'h6;
    targets[1] = 32'h200;
    fill_ramp();
    for (int t = 0; t < 2; t++) begin
      OutReady = 1'b1; Halt = 1'b0; RedirectValid = 1'b0;
      do_reset();
      for (int c = 0; c < 3; c++) step();
      RedirectValid = 1'b1; RedirectTarget = targets[t];
      step();
      total++;
      if (FetchFault !== 1'b1 || OutValid !== 1'b0 || ImemAddress !== targets[t]) begin
        bad++;
        $display("FAIL fault_target t=%h: got f=%b v=%b addr=%h want f=1 v=0",
                 targets[t], FetchFault, OutValid, ImemAddress);
      end
      RedirectTarget = 32'h10;
      for (int c = 0; c < 5; c++) begin
        step();
        RedirectValid = 1'b0;
        total++;
        if (FetchFault !== 1'b1 || OutValid !== 1'b0 || ImemAddress !== targets[t]) begin
          bad++;
          $display("FAIL fault_sticky t=%h c=%0d: got f=%b v=%b addr=%h",
                   targets[t], c, FetchFault, OutValid, ImemAddress);
        end
      end
    end
  endtask

  task automatic test_fault_seq();
    logic [31:0] heads [$];
    fill_ramp();
    OutReady = 1'b1; Halt = 1'b0; RedirectValid = 1'b0;
    do_reset();
    RedirectValid = 1'b1; RedirectTarget = 32'h1F8;
    step();
    RedirectValid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (OutValid) begin
        heads.push_back(OutPC);
        total++;
        if (OutInstruction !== OutPC) begin
          bad++;
          $display("FAIL fault_seq_word: got %h want %h", OutInstruction, OutPC);
        end
      end
    end
    total++;
    if (heads.size() != 2 || heads[0] !== 32'h1F8 || heads[1] !== 32'h1FC || FetchFault !== 1'b1) begin
      bad++;
      $display("FAIL fault_seq: got n=%0d f=%b want n=2 (1f8,1fc) f=1", heads.size(), FetchFault);
    end
    do_reset();
    total++;
    if (ImemAddress !== 32'h0 || FetchFault !== 1'b0) begin
      bad++;
      $display("FAIL fault_clear: got addr=%h f=%b want addr=0 f=0", ImemAddress, FetchFault);
    end
    step();
    total++;
    if (OutValid !== 1'b1 || OutPC !== 32'h0) begin
      bad++;
      $display("FAIL fault_restart: got v=%b pc=%h want v=1 pc=0", OutValid, OutPC);
    end
  endtask

  task automatic test_random();
    int r;
    logic [63:0] head;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    OutReady = 1'b1; Halt = 1'b0; RedirectValid = 1'b0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (m_state == M_FAULT) Rst = ($urandom % 6 == 0);
      else Rst = ($urandom % 100 == 0);
      RedirectValid = ($urandom % 10 == 0);
      r = $urandom % 8;
      if (r == 0)      RedirectTarget = 32'($urandom_range(0, 127) * 4 + 2);
      else if (r == 1) RedirectTarget = 32'h200 + 32'(($urandom % 64) * 4);
      else if (r == 2) RedirectTarget = 32'h1F0 + 32'(($urandom % 4) * 4);
      else             RedirectTarget = 32'($urandom_range(0, 127) * 4);
      Halt = ($urandom % 5 == 0);
      OutReady = ($urandom % 4 != 0);
      step();
      total++;
      if (OutValid !== (m_q.size() > 0) || Occupancy !== 2'(m_q.size()) ||
          ImemAddress !== m_pc || FetchFault !== m_fault) begin
        bad++;
        $display("FAIL rand_ctrl c=%0d: got v=%b occ=%0d addr=%h f=%b want occ=%0d addr=%h f=%b",
                 c, OutValid, Occupancy, ImemAddress, FetchFault, m_q.size(), m_pc, m_fault);
      end
      if (m_q.size() > 0) begin
        head = m_q[0];
        total++;
        if (OutPC !== head[31:0] || OutInstruction !== head[63:32] || OutPCPlus4 !== head[31:0] + 32'd4) begin
          bad++;
          $display("FAIL rand_head c=%0d: got pc=%h ins=%h pc4=%h want pc=%h ins=%h",
                   c, OutPC, OutInstruction, OutPCPlus4, head[31:0], head[63:32]);
        end
      end
    end
    Rst = 1'b0; RedirectValid = 1'b0; Halt = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    Rst = 1'b1;
    RedirectValid = 1'b0;
    RedirectTarget = 32'h0;
    Halt = 1'b0;
    OutReady = 1'b0;
    fill_ramp();
    m_pc = 32'h0;
    m_state = M_RUN;
    m_fault = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_fault_target();
    test_fault_seq();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Sequences the 128-word instruction memory for the MIPS core.
- Owns the fetch PC, drives the memory address, and buffers fetched words in a 2-entry prefetch queue.
- Hands words to decode over a valid/ready handshake.
- Handles branch/jump redirects (with flush), halt requests and address faults. Sits between the instruction memory and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- IMEM_WORDS, 128, instruction memory depth in words; legal byte addresses are 0 .. IMEM_WORDS*4-4.
- BUF_DEPTH, 2, prefetch queue entries (power of two, ≥2).

Ports:
- Clk in 1: single system clock, rising edge.
- Rst in 1: synchronous reset, active-high.
- ImemAddress out 32: byte address to instruction memory.
- ImemInstruction in 32: memory read data, combinational from ImemAddress.
- RedirectValid in 1: branch/jump taken this cycle.
- RedirectTarget in 32: new PC (byte address).
- Halt in 1: level; stop issuing new fetches while high.
- OutValid out 1: queue head valid.
- OutReady in 1: decode accepts head.
- OutInstruction out 32: head instruction word.
- OutPC out 32: byte address of head instruction.
- OutPCPlus4 out 32: OutPC + 4.
- FetchFault out 1: sticky fault flag.
- Occupancy out 2: queue entry count, 0..BUF_DEPTH.

Behaviour:
- Clock and reset: one clock, Clk; reset Rst is synchronous and active-high. On Rst, outputs and state reset as follows.
  - FetchPC = RESET_PC, so ImemAddress = RESET_PC.
  - Queue is emptied: OutValid = 0, Occupancy = 0.
  - OutInstruction, OutPC and OutPCPlus4 = 0.
  - FetchFault = 0; state = RUN.
  - Rst overrides all other inputs in the same cycle.
- ImemAddress is always equal to FetchPC (combinational).
- States:
  - RUN: fetch allowed.
  - HALTED: no fetches; queue still drains.
  - FAULT: no fetches; queue drains; sticky until Rst.
- Transitions:
  - RUN -> HALTED when Halt = 1.
  - HALTED -> RUN when Halt = 0.
  - RUN/HALTED -> FAULT on a bad address (see Faults).
- pop = OutValid & OutReady.
- push occurs in RUN when all of the following hold:
  - RedirectValid = 0;
  - FetchPC is legal;
  - Occupancy < BUF_DEPTH, or pop = 1 (a simultaneous pop and push when full is allowed).
- On push:
  - Enqueue {ImemInstruction, FetchPC} at the tail.
  - FetchPC <= FetchPC + 4.
  - Latency: a word fetched in cycle N appears at the head in cycle N+1 if the queue was empty.
- Pop removes the head; OutInstruction/OutPC update in the next cycle.
- Occupancy update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Redirect (highest priority after Rst):
  - Flush the queue: Occupancy = 0 and OutValid = 0 next cycle, even if pop = 1 this cycle.
  - FetchPC <= RedirectTarget; no push this cycle.
  - Accepted in RUN and HALTED; state is unchanged unless the target is bad.
  - Ignored in FAULT.
- Faults:
  - Bad address: bits [1:0] ≠ 0, or address ≥ IMEM_WORDS*4.
  - Bad RedirectTarget: flush, FetchPC <= target, state -> FAULT, FetchFault = 1 next cycle.
  - Sequential FetchPC reaching IMEM_WORDS*4 while in RUN: no push, state -> FAULT next cycle.
  - Existing queue entries remain poppable in FAULT.
- Halt and redirect in the same cycle: the redirect is applied and state goes to HALTED.
- Word index into memory is FetchPC[8:2] for the default depth; the upper address bits are covered by the range check.
- No combinational path from OutReady to ImemAddress other than through registered state.

Test Plan:
- Reset, OutReady = 1, memory[i] = i*4:
  - OutValid rises in cycle 1.
  - OutPC sequence 0, 4, 8, ….
  - OutInstruction = OutPC; OutPCPlus4 = OutPC + 4.
- Backpressure, OutReady = 0 from reset:
  - Occupancy goes 1, 2 and holds at 2; FetchPC holds at 8; head stays PC = 0.
  - Raising OutReady for 1 cycle: pop and push together, Occupancy stays 2, FetchPC = 12.
- Redirect:
  - RedirectValid = 1, target 0x10, asserted while Occupancy = 2 and OutReady = 1.
  - Next cycle: OutValid = 0, Occupancy = 0, ImemAddress = 0x10.
  - Following cycle: OutPC = 0x10.
- Halt:
  - Halt = 1 for 3 cycles with OutReady = 1.
  - Queue drains to 0 with no new pushes; FetchPC is frozen.
  - On Halt = 0, fetch resumes at the frozen PC with no skipped addresses.
- Faults:
  - RedirectTarget 0x6 -> FetchFault = 1, no further OutValid; same result for target 0x200.
  - Sequential run from 0x1F8 -> entries for 0x1F8 and 0x1FC delivered, then FetchFault = 1.
  - Rst clears the fault and restarts from 0.
- Simultaneous events:
  - Rst together with RedirectValid: reset wins, ImemAddress = RESET_PC.
  - Redirect together with pop: the popped head is consumed once and never re-presented.
